// File: rtl/core_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer and program memory.
// master: sequencer (drives req/addr); slave: memory (drives ack/rdata).
interface core_sequencer_if #(
  parameter int XLEN = 32
) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/execute controller: owns PC and IR, run/step/halt control.
// Ports: clk, reset, run, step, halt_req, imem (fetch if), instr, rf_we, pc,
//        halted, trap, instret.
module core_sequencer #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] PC_RESET   = '0,
  parameter int              PMEM_DEPTH = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                step,
  input  logic                halt_req,
  core_sequencer_if.master    imem,
  output logic [31:0]         instr,
  output logic                rf_we,
  output logic [XLEN-1:0]     pc,
  output logic                halted,
  output logic                trap,
  output logic [31:0]         instret
);

  localparam logic [1:0] S_HALTED = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  // First address past the program; retiring into it halts.
  localparam logic [XLEN-1:0] PC_END =
    PC_RESET + XLEN'(4 * PMEM_DEPTH);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     instret_q, instret_d;
  logic            trap_q, trap_d;
  logic            hp_q, hp_d;
  logic            sm_q, sm_d;

  logic [XLEN-1:0] pc_inc;
  logic            is_legal;
  logic            is_ebreak;
  logic            stop;

  assign pc_inc    = pc_q + XLEN'(4);
  assign is_legal  = (instr_q[6:0] == 7'b0010011) ||
                     (instr_q[6:0] == 7'b0110011);
  assign is_ebreak = (instr_q == EBREAK);
  assign stop      = hp_q || halt_req || sm_q ||
                     (pc_inc == PC_END);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    trap_d    = trap_q;
    hp_d      = hp_q;
    sm_d      = sm_q;
    unique case (state_q)
      S_HALTED: begin
        hp_d = 1'b0;
        if (!trap_q && !halt_req) begin
          if (run) begin
            state_d = S_FETCH;
            sm_d    = 1'b0;
          end else if (step) begin
            state_d = S_FETCH;
            sm_d    = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (halt_req) hp_d = 1'b1;
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_HALTED;
        hp_d    = 1'b0;
        sm_d    = 1'b0;
        unique case (1'b1)
          is_legal: begin
            pc_d      = pc_inc;
            instret_d = instret_q + 32'd1;
            if (!stop) begin
              state_d = S_FETCH;
              hp_d    = hp_q;
              sm_d    = sm_q;
            end
          end
          is_ebreak: ;
          default: trap_d = 1'b1;
        endcase
      end
      default: state_d = S_HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_HALTED;
      pc_q      <= PC_RESET;
      instr_q   <= NOP;
      instret_q <= '0;
      trap_q    <= 1'b0;
      hp_q      <= 1'b0;
      sm_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      hp_q      <= hp_d;
      sm_q      <= sm_d;
    end
  end

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign rf_we          = (state_q == S_EXEC) && is_legal;
  assign pc             = pc_q;
  assign halted         = (state_q == S_HALTED);
  assign trap           = trap_q;
  assign instret        = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: cycle table for a run, plus
// step, trap, wait-state, short-program, halt and reset sequences.
module tb_core_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, run, step, halt_req;
  logic reset1, run1;

  logic [31:0] instr0, pc0, ir0, instr1, pc1, ir1;
  logic        we0, h0, t0, we1, h1, t1;

  core_sequencer_if #(.XLEN(32)) if0 ();
  core_sequencer_if #(.XLEN(32)) if1 ();

  core_sequencer #(
    .XLEN(32), .PC_RESET(32'h0), .PMEM_DEPTH(64)
  ) dut0 (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .halt_req(halt_req), .imem(if0.master),
    .instr(instr0), .rf_we(we0), .pc(pc0),
    .halted(h0), .trap(t0), .instret(ir0)
  );

  core_sequencer #(
    .XLEN(32), .PC_RESET(32'h0), .PMEM_DEPTH(4)
  ) dut1 (
    .clk(clk), .reset(reset1), .run(run1), .step(1'b0),
    .halt_req(1'b0), .imem(if1.master),
    .instr(instr1), .rf_we(we1), .pc(pc1),
    .halted(h1), .trap(t1), .instret(ir1)
  );

  // Program memories with optional wait states on dut0
  logic [31:0] mem0 [64];
  logic [31:0] mem1 [4];
  int          delay0 = 0;
  int          wcnt0 = 0;
  logic        force_ack = 1'b0;

  assign if0.imem_ack =
    (if0.imem_req && wcnt0 == delay0) || force_ack;
  assign if0.imem_rdata =
    force_ack ? 32'h0000007F : mem0[if0.imem_addr[7:2]];
  assign if1.imem_ack   = if1.imem_req;
  assign if1.imem_rdata = mem1[if1.imem_addr[3:2]];

  // Register-file model (addi only) and event counters
  logic [31:0] regs [32];
  logic        clr_regs = 1'b0;
  int          we_cnt = 0, req_cnt0 = 0, req_cnt1 = 0;

  always @(posedge clk) begin
    if (!if0.imem_req || if0.imem_ack) wcnt0 <= 0;
    else wcnt0 <= wcnt0 + 1;
    if (we0) we_cnt <= we_cnt + 1;
    if (if0.imem_req) req_cnt0 <= req_cnt0 + 1;
    if (if1.imem_req) req_cnt1 <= req_cnt1 + 1;
    if (clr_regs) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we0 && instr0[6:0] == 7'b0010011
                 && instr0[14:12] == 3'b000
                 && instr0[11:7] != 5'd0) begin
      regs[instr0[11:7]] <= regs[instr0[19:15]] +
        {{20{instr0[31]}}, instr0[31:20]};
    end
  end

  int pass_cnt = 0, total = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(input int rd,
                                       input int rs1,
                                       input int imm);
    return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
  endfunction

  task automatic load_prog_a();
    for (int i = 0; i < 64; i++) mem0[i] = 32'h13;
    mem0[0] = addi(5, 0, 120);
    mem0[1] = addi(5, 0, 200);
    mem0[2] = addi(5, 5, 2000);
    mem0[3] = 32'h00100073;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
    clr_regs = 1'b1;
    tick();
    tick();
    reset = 1'b0; clr_regs = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (h0) begin ok = 1'b1; break; end
      tick();
    end
    check(name, 32'(ok), 32'd1);
  endtask

  typedef struct {
    bit          run;
    bit          halt;
    bit          req;
    bit          we;
    bit          hlt;
    logic [31:0] pc;
    logic [31:0] ir;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(bit r, bit hq, bit rq, bit w,
                              bit hl, int p, int n);
    vec_t v;
    v.run = r; v.halt = hq; v.req = rq; v.we = w;
    v.hlt = hl; v.pc = 32'(p); v.ir = 32'(n);
    return v;
  endfunction

  initial begin
    int snap, snap2, waits, stab_err;
    logic [31:0] pa, pi;
    bit prev_wait;
    int we_t [$];

    vecs[0]  = mk(1, 0, 0, 0, 1, 0, 0);
    vecs[1]  = mk(0, 0, 1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 0, 0, 4, 1);
    vecs[4]  = mk(0, 0, 0, 1, 0, 4, 1);
    vecs[5]  = mk(1, 0, 1, 0, 0, 8, 2);
    vecs[6]  = mk(0, 0, 0, 1, 0, 8, 2);
    vecs[7]  = mk(0, 0, 1, 0, 0, 12, 3);
    vecs[8]  = mk(0, 0, 0, 0, 0, 12, 3);
    vecs[9]  = mk(1, 1, 0, 0, 1, 12, 3);
    vecs[10] = mk(0, 0, 0, 0, 1, 12, 3);

    for (int i = 0; i < 4; i++) mem1[i] = addi(1, 1, 1);
    reset1 = 1'b1; run1 = 1'b0;
    load_prog_a();
    do_reset();
    reset1 = 1'b0;

    // Reset state
    check("rst_pc", pc0, 32'h0);
    check("rst_instr", instr0, 32'h13);
    check("rst_req", 32'(if0.imem_req), 32'd0);
    check("rst_we", 32'(we0), 32'd0);
    check("rst_halted", 32'(h0), 32'd1);
    check("rst_trap", 32'(t0), 32'd0);
    check("rst_instret", ir0, 32'd0);

    // Continuous run, zero-wait memory, cycle by cycle
    for (int i = 0; i < 11; i++) begin
      run = vecs[i].run; halt_req = vecs[i].halt;
      #1;
      check($sformatf("run%0d_req", i),
            32'(if0.imem_req), 32'(vecs[i].req));
      check($sformatf("run%0d_we", i), 32'(we0), 32'(vecs[i].we));
      check($sformatf("run%0d_halted", i),
            32'(h0), 32'(vecs[i].hlt));
      check($sformatf("run%0d_pc", i), pc0, vecs[i].pc);
      check($sformatf("run%0d_addr", i), if0.imem_addr, vecs[i].pc);
      check($sformatf("run%0d_instret", i), ir0, vecs[i].ir);
      tick();
      run = 1'b0; halt_req = 1'b0;
    end
    check("run_x5", regs[5], 32'd2200);
    check("run_trap", 32'(t0), 32'd0);

    // Single step three times
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      snap = we_cnt;
      step = 1'b1;
      tick();
      step = 1'b0;
      wait_halt($sformatf("step%0d_timeout", k));
      check($sformatf("step%0d_we", k), 32'(we_cnt - snap), 32'd1);
      check($sformatf("step%0d_pc", k), pc0, 32'(4 * k));
      check($sformatf("step%0d_instret", k), ir0, 32'(k));
    end
    check("step_x5", regs[5], 32'd2200);

    // Illegal instruction traps and locks out run/step
    mem0[1] = 32'h0000007F;
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    wait_halt("trap_timeout");
    check("trap_flag", 32'(t0), 32'd1);
    check("trap_pc", pc0, 32'd4);
    check("trap_instret", ir0, 32'd1);
    snap = req_cnt0;
    run = 1'b1;
    tick();
    run = 1'b0; step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("trap_noreq", 32'(req_cnt0 - snap), 32'd0);
    check("trap_sticky", 32'(t0), 32'd1);
    load_prog_a();

    // Wait-stated fetch: ack on third cycle of each request
    delay0 = 2;
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    waits = 0; stab_err = 0; prev_wait = 1'b0;
    pa = '0; pi = '0;
    for (int i = 0; i < 60 && !h0; i++) begin
      if (we0) we_t.push_back(i);
      if (if0.imem_req && !if0.imem_ack) begin
        if (prev_wait && (if0.imem_addr != pa || instr0 != pi))
          stab_err++;
        pa = if0.imem_addr; pi = instr0;
        prev_wait = 1'b1;
        waits++;
      end else begin
        prev_wait = 1'b0;
      end
      tick();
    end
    check("wait_halted", 32'(h0), 32'd1);
    check("wait_stable", 32'(stab_err), 32'd0);
    check("wait_waits", 32'(waits), 32'd8);
    check("wait_nwe", 32'(we_t.size()), 32'd3);
    if (we_t.size() == 3) begin
      check("wait_period1", 32'(we_t[1] - we_t[0]), 32'd4);
      check("wait_period2", 32'(we_t[2] - we_t[1]), 32'd4);
    end
    check("wait_pc", pc0, 32'd12);
    delay0 = 0;

    // Short program ends at PMEM_DEPTH
    snap2 = req_cnt1;
    run1 = 1'b1;
    tick();
    run1 = 1'b0;
    for (int i = 0; i < 30 && !h1; i++) tick();
    for (int i = 0; i < 4; i++) tick();
    check("depth_halted", 32'(h1), 32'd1);
    check("depth_pc", pc1, 32'd16);
    check("depth_instret", ir1, 32'd4);
    check("depth_nreq", 32'(req_cnt1 - snap2), 32'd4);
    check("depth_trap", 32'(t1), 32'd0);

    // halt_req during fetch of instruction 2
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    check("hreq_infetch", 32'(if0.imem_req), 32'd1);
    snap = we_cnt;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_halt("hreq_timeout");
    check("hreq_we", 32'(we_cnt - snap), 32'd1);
    check("hreq_pc", pc0, 32'd8);

    // Reset during a later fetch, then a stray ack
    delay0 = 2;
    run = 1'b1;
    tick();
    run = 1'b0;
    check("rstf_infetch", 32'(if0.imem_req), 32'd1);
    reset = 1'b1;
    tick();
    check("rstf_req", 32'(if0.imem_req), 32'd0);
    check("rstf_pc", pc0, 32'd0);
    check("rstf_instret", ir0, 32'd0);
    reset = 1'b0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    #1;
    check("late_ack_halted", 32'(h0), 32'd1);
    check("late_ack_instr", instr0, 32'h13);
    check("late_ack_req", 32'(if0.imem_req), 32'd0);
    check("late_ack_trap", 32'(t0), 32'd0);
    delay0 = 0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
